// File: rtl/oric_mem_pkg.sv
// Shared types and constants for the Oric SDRAM port arbiter.
package oric_mem_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} arb_state_t;
    typedef enum logic {G_CPU, G_DSK} grant_t;

    localparam logic [1:0] DS_LO = 2'b01;
    localparam logic [1:0] DS_HI = 2'b10;
    localparam logic [1:0] DS_RD = 2'b11;

    function automatic logic [1:0] byte_strobe(input logic we, input logic a0);
        if (!we)
            return DS_RD;
        return a0 ? DS_HI : DS_LO;
    endfunction

endpackage

// File: rtl/sdram_port_arbiter_sync.sv
// Two-flop synchroniser bringing the clk_72 ack toggle into clk_24.
module toggle_sync (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    // Deliberately not reset: the arbiter realigns its request toggle to
    // this output while reset is held, so it must keep tracking mem_ack.
    always_ff @(posedge clk) begin
        r_meta <= d;
        r_sync <= r_meta;
    end

    assign q = r_sync;

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares the toggle-handshake SDRAM port between the Oric CPU bus and the
// disk track-buffer loader, with bounded CPU priority.
module sdram_port_arbiter
    import oric_mem_pkg::*;
#(
    parameter int                ADDR_W    = 24,
    parameter logic [ADDR_W-1:0] DISK_BASE = 24'h010000,
    parameter int                CPU_BURST = 4,
    parameter int                TIMEOUT   = 63
) (
    input  logic              clk_24,
    input  logic              reset,
    input  logic              cpu_cs,
    input  logic              cpu_oe,
    input  logic              cpu_we,
    input  logic [15:0]       cpu_a,
    input  logic [7:0]        cpu_d,
    output logic [7:0]        cpu_q,
    output logic              cpu_busy,
    input  logic              dsk_req,
    input  logic              dsk_we,
    input  logic [19:0]       dsk_a,
    input  logic [7:0]        dsk_d,
    output logic [7:0]        dsk_q,
    output logic              dsk_ack,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [1:0]        mem_ds,
    output logic [15:0]       mem_d,
    input  logic [15:0]       mem_q,
    output logic              err_timeout,
    output arb_state_t        dbg_state
);

    localparam int BW = $clog2(CPU_BURST + 1);
    localparam int TW = $clog2(TIMEOUT + 2);

    // Handshake: a request is outstanding while mem_req != ack_s; the
    // arbiter toggles mem_req once per access and the controller answers
    // by making mem_ack equal to it.
    logic          w_ack_s;
    arb_state_t    r_state, w_state_next;
    grant_t        r_grant, w_grant_next;
    logic          w_grant_cpu, w_grant_dsk;
    logic          r_mem_req;
    logic          r_cpu_pend, r_dsk_pend;
    logic          r_cs_oe_d, r_cs_we_d;
    logic [15:0]   r_cpu_a_prev, r_cpu_a;
    logic [7:0]    r_cpu_d, r_dsk_d;
    logic          r_cpu_we, r_dsk_we;
    logic [19:0]   r_dsk_a;
    logic [BW-1:0] r_burst_cnt;
    logic [TW-1:0] r_wait_cnt;
    logic          r_lane_hi;
    logic          w_cpu_detect, w_dsk_accept;
    logic [7:0]    w_lane;

    toggle_sync u_ack_sync (
        .clk (clk_24),
        .d   (mem_ack),
        .q   (w_ack_s)
    );

    assign w_cpu_detect = (cpu_cs & cpu_oe & ~r_cs_oe_d)
                        | (cpu_cs & cpu_we & ~r_cs_we_d)
                        | (cpu_cs & cpu_oe & (cpu_a != r_cpu_a_prev));
    assign w_dsk_accept = dsk_req & ~r_dsk_pend & ~((r_state != IDLE) & (r_grant == G_DSK));
    // Lane choice is latched at issue so a newer CPU detect cannot disturb it.
    assign w_lane       = r_lane_hi ? mem_q[15:8] : mem_q[7:0];
    assign cpu_busy     = r_cpu_pend | ((r_state != IDLE) & (r_grant == G_CPU));
    assign mem_req      = r_mem_req;
    assign dbg_state    = r_state;

    always_ff @(posedge clk_24) begin
        if (reset) begin
            r_state <= IDLE;
            r_grant <= G_CPU;
        end else begin
            r_state <= w_state_next;
            r_grant <= w_grant_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_grant_cpu  = 1'b0;
        w_grant_dsk  = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_cpu_pend && (!r_dsk_pend || r_burst_cnt < BW'(CPU_BURST))) begin
                    w_state_next = ISSUE;
                    w_grant_next = G_CPU;
                    w_grant_cpu  = 1'b1;
                end else if (r_dsk_pend) begin
                    w_state_next = ISSUE;
                    w_grant_next = G_DSK;
                    w_grant_dsk  = 1'b1;
                end
            end
            ISSUE:   w_state_next = WAIT;
            WAIT:    if (w_ack_s == r_mem_req) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_24) begin
        r_cs_oe_d    <= cpu_cs & cpu_oe;
        r_cs_we_d    <= cpu_cs & cpu_we;
        r_cpu_a_prev <= cpu_a;
        if (reset) begin
            r_mem_req   <= w_ack_s;
            r_cpu_pend  <= 1'b0;
            r_dsk_pend  <= 1'b0;
            r_burst_cnt <= '0;
            r_wait_cnt  <= '0;
            r_lane_hi   <= 1'b0;
            cpu_q       <= '0;
            dsk_q       <= '0;
            dsk_ack     <= 1'b0;
            mem_a       <= '0;
            mem_we      <= 1'b0;
            mem_ds      <= DS_RD;
            mem_d       <= '0;
            err_timeout <= 1'b0;
        end else begin
            dsk_ack <= 1'b0;

            if (r_state == ISSUE && r_grant == G_CPU)
                r_cpu_pend <= 1'b0;
            if (w_cpu_detect) begin
                r_cpu_pend <= 1'b1;
                r_cpu_a    <= cpu_a;
                r_cpu_d    <= cpu_d;
                r_cpu_we   <= cpu_we;
            end

            if (r_state == ISSUE && r_grant == G_DSK)
                r_dsk_pend <= 1'b0;
            if (w_dsk_accept) begin
                r_dsk_pend <= 1'b1;
                r_dsk_a    <= dsk_a;
                r_dsk_d    <= dsk_d;
                r_dsk_we   <= dsk_we;
            end

            if (!r_dsk_pend || w_grant_dsk)
                r_burst_cnt <= '0;
            else if (w_grant_cpu && r_burst_cnt < BW'(CPU_BURST))
                r_burst_cnt <= r_burst_cnt + 1'b1;

            if (r_state == ISSUE) begin
                r_mem_req  <= ~r_mem_req;
                r_wait_cnt <= '0;
                if (r_grant == G_CPU) begin
                    mem_a     <= ADDR_W'(r_cpu_a);
                    mem_we    <= r_cpu_we;
                    mem_ds    <= byte_strobe(r_cpu_we, r_cpu_a[0]);
                    mem_d     <= {r_cpu_d, r_cpu_d};
                    r_lane_hi <= r_cpu_a[0];
                end else begin
                    mem_a     <= DISK_BASE + ADDR_W'(r_dsk_a);
                    mem_we    <= r_dsk_we;
                    mem_ds    <= byte_strobe(r_dsk_we, r_dsk_a[0]);
                    mem_d     <= {r_dsk_d, r_dsk_d};
                    r_lane_hi <= r_dsk_a[0];
                end
            end

            if (r_state == WAIT) begin
                if (r_wait_cnt == TW'(TIMEOUT))
                    err_timeout <= 1'b1;
                if (r_wait_cnt != {TW{1'b1}})
                    r_wait_cnt <= r_wait_cnt + 1'b1;
            end

            if (r_state == DONE) begin
                if (r_grant == G_CPU) begin
                    if (!mem_we)
                        cpu_q <= w_lane;
                end else begin
                    if (!mem_we)
                        dsk_q <= w_lane;
                    dsk_ack <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter with a toggle-handshake memory model.
module tb_sdram_port_arbiter;
    import oric_mem_pkg::*;

    localparam logic [23:0] DISK_BASE = 24'h010000;

    logic        clk_24 = 1'b0;
    logic        reset  = 1'b1;
    logic        cpu_cs = 1'b0, cpu_oe = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_a  = '0;
    logic [7:0]  cpu_d  = '0;
    logic [7:0]  cpu_q;
    logic        cpu_busy;
    logic        dsk_req = 1'b0, dsk_we = 1'b0;
    logic [19:0] dsk_a  = '0;
    logic [7:0]  dsk_d  = '0;
    logic [7:0]  dsk_q;
    logic        dsk_ack;
    logic        mem_req;
    logic        mem_ack;
    logic [23:0] mem_a;
    logic        mem_we;
    logic [1:0]  mem_ds;
    logic [15:0] mem_d;
    logic [15:0] mem_q;
    logic        err_timeout;
    arb_state_t  dbg_state;

    always #5 clk_24 = ~clk_24;

    sdram_port_arbiter dut (
        .clk_24      (clk_24),
        .reset       (reset),
        .cpu_cs      (cpu_cs),
        .cpu_oe      (cpu_oe),
        .cpu_we      (cpu_we),
        .cpu_a       (cpu_a),
        .cpu_d       (cpu_d),
        .cpu_q       (cpu_q),
        .cpu_busy    (cpu_busy),
        .dsk_req     (dsk_req),
        .dsk_we      (dsk_we),
        .dsk_a       (dsk_a),
        .dsk_d       (dsk_d),
        .dsk_q       (dsk_q),
        .dsk_ack     (dsk_ack),
        .mem_req     (mem_req),
        .mem_ack     (mem_ack),
        .mem_a       (mem_a),
        .mem_we      (mem_we),
        .mem_ds      (mem_ds),
        .mem_d       (mem_d),
        .mem_q       (mem_q),
        .err_timeout (err_timeout),
        .dbg_state   (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: word store plus byte-level expectation store.
    typedef struct {
        logic [23:0] a;
        logic        we;
        logic [1:0]  ds;
        logic [15:0] d;
    } issue_t;

    issue_t      issue_q[$];
    logic [15:0] mem_words [logic [23:0]];
    logic [7:0]  exp_bytes [logic [23:0]];
    logic [7:0]  exp_q[$];
    int          ack_delay = 2;

    function automatic logic [15:0] init_word(input logic [23:0] k);
        return {k[7:0] ^ 8'h5C, k[15:8] ^ k[7:0] ^ 8'h93};
    endfunction

    function automatic logic [7:0] model_byte(input logic [23:0] k);
        logic [15:0] w;
        if (exp_bytes.exists(k))
            return exp_bytes[k];
        w = init_word(k);
        return k[0] ? w[15:8] : w[7:0];
    endfunction

    initial begin : mem_ctrl
        issue_t      it;
        logic [15:0] w;
        logic        req_v;
        mem_ack = 1'b0;
        mem_q   = '0;
        forever begin
            @(negedge clk_24);
            if (!reset && mem_req !== mem_ack) begin
                req_v = mem_req;
                it.a  = mem_a;
                it.we = mem_we;
                it.ds = mem_ds;
                it.d  = mem_d;
                issue_q.push_back(it);
                w = mem_words.exists(mem_a) ? mem_words[mem_a] : init_word(mem_a);
                if (mem_we) begin
                    if (mem_ds[0]) w[7:0]  = mem_d[7:0];
                    if (mem_ds[1]) w[15:8] = mem_d[15:8];
                    mem_words[mem_a] = w;
                end else begin
                    mem_q = w;
                end
                repeat (ack_delay) @(negedge clk_24);
                mem_ack = req_v;
            end
        end
    end

    int         dsk_ack_cnt = 0;
    logic [7:0] dsk_q_seen  = '0;
    always @(negedge clk_24) begin
        if (dsk_ack === 1'b1) begin
            dsk_ack_cnt++;
            dsk_q_seen = dsk_q;
        end
    end

    function automatic logic [1:0] exp_ds(input logic we, input logic a0);
        if (!we) return 2'b11;
        return a0 ? 2'b10 : 2'b01;
    endfunction

    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [7:0] d, input string tag);
        issue_t      it;
        logic [23:0] k;
        int          guard;
        k = {8'h00, a};
        issue_q.delete();
        @(negedge clk_24);
        cpu_cs = 1'b1; cpu_a = a; cpu_d = d; cpu_we = we; cpu_oe = ~we;
        @(negedge clk_24);
        check({tag, "_busy_rise"}, cpu_busy, 1);
        guard = 0;
        while (cpu_busy === 1'b1 && guard < 300) begin
            @(negedge clk_24);
            guard++;
        end
        check({tag, "_busy_fall"}, cpu_busy, 0);
        cpu_cs = 1'b0; cpu_oe = 1'b0; cpu_we = 1'b0;
        check({tag, "_req_count"}, issue_q.size(), 1);
        it = '{a: '0, we: 1'b0, ds: '0, d: '0};
        if (issue_q.size() > 0) it = issue_q[0];
        check({tag, "_mem_a"}, it.a, k);
        check({tag, "_mem_we"}, it.we, we);
        check({tag, "_mem_ds"}, it.ds, exp_ds(we, a[0]));
        if (we) begin
            check({tag, "_mem_d"}, it.d, {d, d});
            exp_bytes[k] = d;
        end else begin
            exp_q.push_back(model_byte(k));
            check({tag, "_cpu_q"}, cpu_q, exp_q.pop_front());
        end
    endtask

    task automatic dsk_access(input logic we, input logic [19:0] a, input logic [7:0] d, input string tag);
        issue_t      it;
        logic [23:0] k;
        int          guard, n0;
        k = DISK_BASE + {4'h0, a};
        issue_q.delete();
        n0 = dsk_ack_cnt;
        @(negedge clk_24);
        dsk_req = 1'b1; dsk_we = we; dsk_a = a; dsk_d = d;
        @(negedge clk_24);
        dsk_req = 1'b0;
        guard = 0;
        while (dsk_ack_cnt == n0 && guard < 300) begin
            @(negedge clk_24);
            guard++;
        end
        repeat (4) @(negedge clk_24);
        check({tag, "_ack_pulses"}, dsk_ack_cnt - n0, 1);
        check({tag, "_req_count"}, issue_q.size(), 1);
        it = '{a: '0, we: 1'b0, ds: '0, d: '0};
        if (issue_q.size() > 0) it = issue_q[0];
        check({tag, "_mem_a"}, it.a, k);
        check({tag, "_mem_we"}, it.we, we);
        check({tag, "_mem_ds"}, it.ds, exp_ds(we, a[0]));
        if (we) begin
            check({tag, "_mem_d"}, it.d, {d, d});
            exp_bytes[k] = d;
        end else begin
            exp_q.push_back(model_byte(k));
            check({tag, "_dsk_q"}, dsk_q_seen, exp_q.pop_front());
        end
    endtask

    initial begin : stim
        int          guard, n0, ncpu;
        logic        found;
        logic [15:0] ra;
        logic [19:0] rd;

        // Reset state
        repeat (6) @(negedge clk_24);
        check("rst_cpu_q", cpu_q, 0);
        check("rst_dsk_q", dsk_q, 0);
        check("rst_dsk_ack", dsk_ack, 0);
        check("rst_cpu_busy", cpu_busy, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_ds", mem_ds, 2'b11);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_d", mem_d, 0);
        check("rst_err", err_timeout, 0);
        check("rst_req_aligned", mem_req, mem_ack);
        reset = 1'b0;

        // Directed CPU and disk accesses
        mem_words[24'h001235] = 16'hAB12;
        exp_bytes[24'h001235] = 8'hAB;
        cpu_access(1'b0, 16'h1235, 8'h00, "cpu_rd_1235");
        check("cpu_rd_1235_const", cpu_q, 8'hAB);
        cpu_access(1'b1, 16'h0400, 8'h5A, "cpu_wr_0400");
        cpu_access(1'b0, 16'h0400, 8'h00, "cpu_rd_0400");
        ack_delay = 5;
        dsk_access(1'b0, 20'h00010, 8'h00, "dsk_rd_10");
        check("dsk_rd_10_lowbyte", dsk_q_seen, init_word(24'h010010) & 16'h00FF);

        // Randomized mixed traffic
        for (int i = 0; i < 40; i++) begin
            ack_delay = $urandom_range(1, 6);
            ra = 16'h2000 + 16'($urandom_range(0, 15));
            rd = 20'h00300 + 20'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: cpu_access(1'b0, ra, 8'h00, "rnd_cpu_rd");
                1: cpu_access(1'b1, ra, 8'($urandom), "rnd_cpu_wr");
                2: dsk_access(1'b0, rd, 8'h00, "rnd_dsk_rd");
                default: dsk_access(1'b1, rd, 8'($urandom), "rnd_dsk_wr");
            endcase
        end

        // Bounded CPU priority: disk waits for exactly CPU_BURST grants
        ack_delay = 2;
        issue_q.delete();
        n0 = dsk_ack_cnt;
        @(negedge clk_24);
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_we = 1'b0; cpu_a = 16'h3000;
        guard = 0;
        while (issue_q.size() == 0 && guard < 100) begin
            @(negedge clk_24);
            cpu_a = cpu_a + 16'd1;
            guard++;
        end
        issue_q.delete();
        dsk_req = 1'b1; dsk_we = 1'b0; dsk_a = 20'h00500;
        @(negedge clk_24);
        dsk_req = 1'b0;
        cpu_a = cpu_a + 16'd1;
        guard = 0;
        while (dsk_ack_cnt == n0 && guard < 400) begin
            @(negedge clk_24);
            cpu_a = cpu_a + 16'd1;
            guard++;
        end
        cpu_cs = 1'b0; cpu_oe = 1'b0;
        guard = 0;
        while (cpu_busy === 1'b1 && guard < 100) begin
            @(negedge clk_24);
            guard++;
        end
        check("burst_idle", cpu_busy, 0);
        check("burst_dsk_ack", dsk_ack_cnt - n0, 1);
        ncpu  = 0;
        found = 1'b0;
        foreach (issue_q[i]) begin
            if (!found && issue_q[i].a >= DISK_BASE) found = 1'b1;
            else if (!found) ncpu++;
        end
        check("burst_dsk_found", found, 1);
        check("burst_cpu_grants", ncpu, 4);
        check("burst_dsk_q", dsk_q_seen, model_byte(DISK_BASE + 24'h000500));

        // Timeout flag with a withheld ack
        ack_delay = 70;
        issue_q.delete();
        @(negedge clk_24);
        cpu_cs = 1'b1; cpu_oe = 1'b1; cpu_a = 16'h4001;
        guard = 0;
        while (issue_q.size() == 0 && guard < 50) begin
            @(negedge clk_24);
            guard++;
        end
        check("to_issued", issue_q.size(), 1);
        repeat (55) @(negedge clk_24);
        check("to_err_early", err_timeout, 0);
        repeat (13) @(negedge clk_24);
        check("to_err_set", err_timeout, 1);
        guard = 0;
        while (cpu_busy === 1'b1 && guard < 200) begin
            @(negedge clk_24);
            guard++;
        end
        check("to_completed", cpu_busy, 0);
        check("to_cpu_q", cpu_q, model_byte(24'h004001));
        check("to_err_sticky", err_timeout, 1);
        cpu_cs = 1'b0; cpu_oe = 1'b0;

        // Reset during WAIT with the ack landing inside reset
        ack_delay = 20;
        issue_q.delete();
        n0 = dsk_ack_cnt;
        @(negedge clk_24);
        dsk_req = 1'b1; dsk_we = 1'b0; dsk_a = 20'h00600;
        @(negedge clk_24);
        dsk_req = 1'b0;
        guard = 0;
        while (issue_q.size() == 0 && guard < 50) begin
            @(negedge clk_24);
            guard++;
        end
        repeat (3) @(negedge clk_24);
        reset = 1'b1;
        repeat (30) @(negedge clk_24);
        reset = 1'b0;
        @(negedge clk_24);
        check("rr_req_aligned", mem_req, mem_ack);
        check("rr_err_cleared", err_timeout, 0);
        check("rr_busy", cpu_busy, 0);
        repeat (10) @(negedge clk_24);
        check("rr_no_dsk_ack", dsk_ack_cnt - n0, 0);
        ack_delay = 3;
        cpu_access(1'b0, 16'h4100, 8'h00, "rr_cpu_rd");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
